// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access unit: lane steering, load sign-extension and
// req/ack handshake with timeout. Stalls the pipeline while an access is outstanding.
module mem_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_aluo,
   input  logic [31:0] i_rv2,
   input  logic [1:0]  i_mem_r,
   input  logic [1:0]  i_mem_w,
   output logic        o_stall,
   output logic [31:0] o_rdata,
   output logic        o_rdata_valid,
   output logic        o_misalign,
   output logic        o_err,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r;
   logic [1:0]    size_r;
   logic [1:0]    lo_r;
   logic          load_r;

   logic          store_s;
   logic          load_s;
   logic          op_s;
   logic [1:0]    size_s;
   logic          aligned_s;

   function automatic logic aligned_f(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   aligned_f = 1'b1;
         2'b01:   aligned_f = (lo[0] == 1'b0);
         2'b10:   aligned_f = (lo == 2'b00);
         default: aligned_f = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   be_f = 4'b0001 << lo;
         2'b01:   be_f = lo[1] ? 4'b1100 : 4'b0011;
         2'b10:   be_f = 4'b1111;
         default: be_f = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] rv2);
      case (size)
         2'b00:   wdata_f = {4{rv2[7:0]}};
         2'b01:   wdata_f = {2{rv2[15:0]}};
         2'b10:   wdata_f = rv2;
         default: wdata_f = 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] extract_f(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] word);
      logic [31:0] sh;
      case (size)
         2'b00: begin
            sh = word >> {lo, 3'b000};
            extract_f = {{24{sh[7]}}, sh[7:0]};
         end
         2'b01: begin
            sh = word >> {lo[1], 4'b0000};
            extract_f = {{16{sh[15]}}, sh[15:0]};
         end
         default: begin
            sh = word;
            extract_f = sh;
         end
      endcase
   endfunction

   // A store wins when both codes are present; the load is then ignored.
   assign store_s   = (i_mem_w != 2'b11);
   assign load_s    = !store_s && (i_mem_r != 2'b11);
   assign op_s      = store_s || load_s;
   assign size_s    = store_s ? i_mem_w : i_mem_r;
   assign aligned_s = aligned_f(size_s, i_aluo[1:0]);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state plus the same-cycle stall and misalign indications.
   always_comb begin
      state_s    = state_r;
      o_stall    = 1'b0;
      o_misalign = 1'b0;
      case (state_r)
         IDLE: begin
            if (op_s && aligned_s) begin
               o_stall = 1'b1;
               state_s = REQ;
            end else if (op_s) begin
               o_misalign = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            o_stall = 1'b1;
            if (dm_ack || (cnt_r == CNT_LAST)) begin
               state_s = DONE;
            end else begin
               state_s = REQ;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Memory-port registers, timeout counter, load capture and completion pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dm_req        <= 1'b0;
         dm_we         <= 1'b0;
         dm_addr       <= 32'h0000_0000;
         dm_wdata      <= 32'h0000_0000;
         dm_be         <= 4'b0000;
         o_rdata       <= 32'h0000_0000;
         o_rdata_valid <= 1'b0;
         o_err         <= 1'b0;
         cnt_r         <= '0;
         size_r        <= 2'b00;
         lo_r          <= 2'b00;
         load_r        <= 1'b0;
      end else begin
         o_rdata_valid <= 1'b0;
         o_err         <= 1'b0;
         case (state_r)
            IDLE: begin
               if (op_s && aligned_s) begin
                  dm_req   <= 1'b1;
                  dm_we    <= store_s;
                  dm_addr  <= {i_aluo[31:2], 2'b00};
                  dm_be    <= store_s ? be_f(size_s, i_aluo[1:0]) : 4'b1111;
                  dm_wdata <= store_s ? wdata_f(size_s, i_rv2) : 32'h0000_0000;
                  size_r   <= size_s;
                  lo_r     <= i_aluo[1:0];
                  load_r   <= load_s;
                  cnt_r    <= '0;
               end
            end
            REQ: begin
               if (dm_ack) begin
                  dm_req        <= 1'b0;
                  o_rdata_valid <= load_r;
                  if (load_r) begin
                     o_rdata <= extract_f(size_r, lo_r, dm_rdata);
                  end
               end else if (cnt_r == CNT_LAST) begin
                  dm_req <= 1'b0;
                  o_err  <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               dm_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, misalign, timeout and
// asynchronous reset during an outstanding request.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_aluo, i_rv2;
   logic [1:0]  i_mem_r, i_mem_w;
   logic        o_stall, o_rdata_valid, o_misalign, o_err;
   logic [31:0] o_rdata;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;

   int n_cmp = 0;
   int n_err = 0;
   int n_req;

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_aluo(i_aluo), .i_rv2(i_rv2),
      .i_mem_r(i_mem_r), .i_mem_w(i_mem_w), .o_stall(o_stall), .o_rdata(o_rdata),
      .o_rdata_valid(o_rdata_valid), .o_misalign(o_misalign), .o_err(o_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] op,
                          input logic [31:0] word, input logic [31:0] exp);
      i_aluo  = addr;
      i_mem_r = op;
      i_mem_w = 2'b11;
      #1;
      chk({tag, "_stall_idle"}, 32'(o_stall), 32'd1);
      tick();
      chk({tag, "_req"}, 32'(dm_req), 32'd1);
      chk({tag, "_we"}, 32'(dm_we), 32'd0);
      chk({tag, "_be"}, 32'(dm_be), 32'hF);
      chk({tag, "_addr"}, dm_addr, {addr[31:2], 2'b00});
      chk({tag, "_stall_req"}, 32'(o_stall), 32'd1);
      dm_ack   = 1'b1;
      dm_rdata = word;
      tick();
      dm_ack  = 1'b0;
      i_mem_r = 2'b11;
      chk({tag, "_stall_done"}, 32'(o_stall), 32'd0);
      chk({tag, "_req_done"}, 32'(dm_req), 32'd0);
      chk({tag, "_valid"}, 32'(o_rdata_valid), 32'd1);
      chk({tag, "_rdata"}, o_rdata, exp);
      tick();
      chk({tag, "_valid_off"}, 32'(o_rdata_valid), 32'd0);
      chk({tag, "_rdata_hold"}, o_rdata, exp);
   endtask

   initial begin
      rst_n    = 1'b0;
      i_aluo   = 32'h0;
      i_rv2    = 32'h0;
      i_mem_r  = 2'b11;
      i_mem_w  = 2'b11;
      dm_ack   = 1'b0;
      dm_rdata = 32'h0;
      tick();
      tick();
      chk("rst_req", 32'(dm_req), 32'd0);
      chk("rst_be", 32'(dm_be), 32'd0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_stall", 32'(o_stall), 32'd0);
      rst_n = 1'b1;
      tick();

      do_load("ldw", 32'h0000_0100, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // byte store to lane 3
      i_aluo  = 32'h0000_0203;
      i_rv2   = 32'h0000_00A5;
      i_mem_w = 2'b00;
      #1;
      chk("stb_stall_idle", 32'(o_stall), 32'd1);
      tick();
      chk("stb_req", 32'(dm_req), 32'd1);
      chk("stb_we", 32'(dm_we), 32'd1);
      chk("stb_addr", dm_addr, 32'h0000_0200);
      chk("stb_be", 32'(dm_be), 32'h8);
      chk("stb_wdata", dm_wdata, 32'hA5A5_A5A5);
      dm_ack = 1'b1;
      tick();
      dm_ack  = 1'b0;
      i_mem_w = 2'b11;
      chk("stb_stall_done", 32'(o_stall), 32'd0);
      chk("stb_no_valid", 32'(o_rdata_valid), 32'd0);
      chk("stb_rdata_hold", o_rdata, 32'hDEAD_BEEF);
      tick();

      do_load("ldh", 32'h0000_0102, 2'b01, 32'h8001_1234, 32'hFFFF_8001);
      do_load("ldb", 32'h0000_0101, 2'b00, 32'h8001_1234, 32'h0000_0012);

      // misaligned word store
      i_aluo  = 32'h0000_0102;
      i_mem_w = 2'b10;
      #1;
      chk("mis_pulse", 32'(o_misalign), 32'd1);
      chk("mis_stall", 32'(o_stall), 32'd0);
      tick();
      chk("mis_req", 32'(dm_req), 32'd0);
      i_mem_w = 2'b11;
      #1;
      chk("mis_off", 32'(o_misalign), 32'd0);
      tick();
      tick();
      chk("noop_req", 32'(dm_req), 32'd0);
      chk("noop_stall", 32'(o_stall), 32'd0);

      // timeout: no ack
      i_aluo  = 32'h0000_0300;
      i_mem_r = 2'b10;
      tick();
      n_req = 0;
      for (int i = 0; i < 40; i++) begin
         if (dm_req !== 1'b1) break;
         n_req++;
         tick();
      end
      chk("to_req_cycles", 32'(n_req), 32'd16);
      chk("to_err", 32'(o_err), 32'd1);
      chk("to_stall", 32'(o_stall), 32'd0);
      chk("to_valid", 32'(o_rdata_valid), 32'd0);
      chk("to_rdata_hold", o_rdata, 32'h0000_0012);
      i_mem_r = 2'b11;
      tick();
      chk("to_err_off", 32'(o_err), 32'd0);

      // async reset while a request waits for a late ack
      i_aluo  = 32'h0000_0400;
      i_mem_r = 2'b10;
      tick();
      tick();
      tick();
      chk("ar_req_before", 32'(dm_req), 32'd1);
      rst_n   = 1'b0;
      i_mem_r = 2'b11;
      #1;
      chk("ar_req_now", 32'(dm_req), 32'd0);
      chk("ar_stall_now", 32'(o_stall), 32'd0);
      chk("ar_rdata_now", o_rdata, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      dm_ack   = 1'b1;
      dm_rdata = 32'h1234_5678;
      tick();
      dm_ack = 1'b0;
      chk("ar_late_req", 32'(dm_req), 32'd0);
      chk("ar_late_valid", 32'(o_rdata_valid), 32'd0);
      chk("ar_late_rdata", o_rdata, 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
